// File: rtl/l_class_oc_fifo_reader.sv
// Drains start_n words from an upstream FIFO through a one-word hold register into a sink.
// Optional sequence checking of captured words is enabled by FIFO_READER_SEQCHECK_EN.
module l_class_oc_fifo_reader #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start__ENA,
    input  logic [CNT_W-1:0] start_n,
    output logic             start__RDY,
    output logic             fifo_deq__ENA,
    input  logic             fifo_deq__RDY,
    input  logic [31:0]      fifo_first,
    input  logic             fifo_first__RDY,
    output logic             sink_enq__ENA,
    output logic [31:0]      sink_enq_v,
    input  logic             sink_enq__RDY,
    output logic             done,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count,
    input  logic             rule_enable,
    output logic             rule_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic             hold_valid_q, hold_valid_d;
    logic [31:0]      hold_data_q, hold_data_d;

    logic start_fire;
    logic deq_fire;

    assign start__RDY = (state_q == StIdle) || (state_q == StDone);
    assign start_fire = start__ENA && start__RDY;
    assign done       = (state_q == StDone);

    // Outputs that move data are gated by nRST so a mid-run reset blocks them immediately.
    assign rule_ready = nRST && (state_q == StRun) && (remaining_q != '0) && fifo_deq__RDY &&
                        fifo_first__RDY && (!hold_valid_q || sink_enq__RDY);
    assign deq_fire      = rule_enable && rule_ready;
    assign fifo_deq__ENA = deq_fire;
    assign sink_enq__ENA = nRST && hold_valid_q && sink_enq__RDY;
    assign sink_enq_v    = hold_data_q;
    assign word_count    = word_count_q;

`ifdef FIFO_READER_SEQCHECK_EN
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [31:0]      expected_q, expected_d;

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        word_count_d = word_count_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
`ifdef FIFO_READER_SEQCHECK_EN
        err_count_d  = err_count_q;
        expected_d   = expected_q;
`endif

        if (deq_fire) begin
            hold_data_d  = fifo_first;
            hold_valid_d = 1'b1;
            remaining_d  = remaining_q - CNT_W'(1);
            if (word_count_q != {CNT_W{1'b1}}) begin
                word_count_d = word_count_q + CNT_W'(1);
            end
`ifdef FIFO_READER_SEQCHECK_EN
            // A zero word count marks the first capture of the run, which only seeds expected.
            if ((word_count_q != '0) && (fifo_first != expected_q) &&
                (err_count_q != {CNT_W{1'b1}})) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
            expected_d = fifo_first + 32'd1;
`endif
        end else if (sink_enq__ENA) begin
            hold_valid_d = 1'b0;
        end

        case (state_q)
            StIdle, StDone: begin
                if (start_fire) begin
                    remaining_d  = start_n;
                    word_count_d = '0;
                    hold_valid_d = 1'b0;
                    hold_data_d  = '0;
`ifdef FIFO_READER_SEQCHECK_EN
                    err_count_d  = '0;
                    expected_d   = '0;
`endif
                    state_d = (start_n == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if ((remaining_d == '0) && !hold_valid_d) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            word_count_q <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
`ifdef FIFO_READER_SEQCHECK_EN
            err_count_q  <= '0;
            expected_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            word_count_q <= word_count_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
`ifdef FIFO_READER_SEQCHECK_EN
            err_count_q  <= err_count_d;
            expected_q   <= expected_d;
`endif
        end
    end

endmodule

// File: tb/tb_l_class_oc_fifo_reader.sv
// Directed bench for l_class_oc_fifo_reader: upstream FIFO and sink are modelled with queues.
module tb_l_class_oc_fifo_reader;

    localparam int unsigned CntW = 16;

    logic            CLK = 1'b0;
    logic            nRST;
    logic            start__ENA;
    logic [CntW-1:0] start_n;
    logic            start__RDY;
    logic            fifo_deq__ENA;
    logic            fifo_deq__RDY;
    logic [31:0]     fifo_first;
    logic            fifo_first__RDY;
    logic            sink_enq__ENA;
    logic [31:0]     sink_enq_v;
    logic            sink_enq__RDY;
    logic            done;
    logic [CntW-1:0] word_count;
    logic [CntW-1:0] err_count;
    logic            rule_enable;
    logic            rule_ready;

    int tests = 0;
    int fails = 0;
    int deq_cnt = 0;
    logic [31:0] fq[$];
    logic [31:0] rx[$];

    always #5 CLK = ~CLK;

    l_class_oc_fifo_reader #(.CNT_W(CntW)) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .start__ENA      (start__ENA),
        .start_n         (start_n),
        .start__RDY      (start__RDY),
        .fifo_deq__ENA   (fifo_deq__ENA),
        .fifo_deq__RDY   (fifo_deq__RDY),
        .fifo_first      (fifo_first),
        .fifo_first__RDY (fifo_first__RDY),
        .sink_enq__ENA   (sink_enq__ENA),
        .sink_enq_v      (sink_enq_v),
        .sink_enq__RDY   (sink_enq__RDY),
        .done            (done),
        .word_count      (word_count),
        .err_count       (err_count),
        .rule_enable     (rule_enable),
        .rule_ready      (rule_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd_fifo();
        fifo_first      = (fq.size() > 0) ? fq[0] : 32'd0;
        fifo_first__RDY = (fq.size() > 0);
    endtask

    // Sample handshakes just before the edge, then apply their effect to the models after it.
    task automatic tick();
        logic        d;
        logic        e;
        logic [31:0] v;
        #1;
        d = fifo_deq__ENA;
        e = sink_enq__ENA;
        v = sink_enq_v;
        @(posedge CLK);
        #1;
        if (d) begin
            if (fq.size() > 0) void'(fq.pop_front());
            deq_cnt++;
        end
        if (e) rx.push_back(v);
        upd_fifo();
    endtask

    task automatic start_run(input logic [CntW-1:0] n);
        start_n    = n;
        start__ENA = 1'b1;
        tick();
        start__ENA = 1'b0;
        #1;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        #1;
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic load(input logic [31:0] base, input int cnt);
        fq.delete();
        rx.delete();
        deq_cnt = 0;
        for (int i = 0; i < cnt; i++) fq.push_back(base + 32'(i));
        upd_fifo();
    endtask

    task automatic chk_rx(input string tag, input logic [31:0] base, input int cnt);
        chk({tag, "_rx_size"}, 32'(rx.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < rx.size(); i++) begin
            chk($sformatf("%s_rx%0d", tag, i), rx[i], base + 32'(i));
        end
    endtask

    initial begin
        logic [31:0] exp_err;

        nRST          = 1'b0;
        start__ENA    = 1'b0;
        start_n       = '0;
        fifo_deq__RDY = 1'b1;
        sink_enq__RDY = 1'b1;
        rule_enable   = 1'b1;
        fq.delete();
        upd_fifo();
        tick();
        tick();
        nRST = 1'b1;
        #1;
        chk("rst_start_rdy", {31'd0, start__RDY}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sink_v", sink_enq_v, 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        chk("rst_ec", 32'(err_count), 32'd0);
        chk("rst_rule_ready", {31'd0, rule_ready}, 32'd0);

        // Streaming at one word per cycle.
        load(32'd10, 4);
        start_run(16'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a_deq%0d", i), {31'd0, fifo_deq__ENA}, 32'd1);
            chk($sformatf("a_enq%0d", i), {31'd0, sink_enq__ENA}, (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) chk($sformatf("a_v%0d", i), sink_enq_v, 32'd10 + 32'(i - 1));
            tick();
            #1;
        end
        chk("a_last_deq", {31'd0, fifo_deq__ENA}, 32'd0);
        chk("a_last_enq", {31'd0, sink_enq__ENA}, 32'd1);
        chk("a_last_v", sink_enq_v, 32'd13);
        chk("a_not_done", {31'd0, done}, 32'd0);
        tick();
        #1;
        chk("a_done", {31'd0, done}, 32'd1);
        chk("a_wc", 32'(word_count), 32'd4);
        chk("a_ec", 32'(err_count), 32'd0);
        chk("a_start_rdy", {31'd0, start__RDY}, 32'd1);
        chk_rx("a", 32'd10, 4);

        // Sink back-pressure holds the first word.
        load(32'd20, 3);
        start_run(16'd3);
        chk("b_deq0", {31'd0, fifo_deq__ENA}, 32'd1);
        sink_enq__RDY = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("b_rr%0d", i), {31'd0, rule_ready}, 32'd0);
            chk($sformatf("b_deq_stall%0d", i), {31'd0, fifo_deq__ENA}, 32'd0);
            chk($sformatf("b_hold%0d", i), sink_enq_v, 32'd20);
            tick();
        end
        chk("b_deq_cnt", 32'(deq_cnt), 32'd1);
        sink_enq__RDY = 1'b1;
        wait_done("b_done", 12);
        chk("b_wc", 32'(word_count), 32'd3);
        chk_rx("b", 32'd20, 3);

        // Sequence check: 5,6,9,10 has one break.
        fq.delete();
        rx.delete();
        foreach (fq[i]) fq[i] = 0;
        fq.push_back(32'd5);
        fq.push_back(32'd6);
        fq.push_back(32'd9);
        fq.push_back(32'd10);
        upd_fifo();
        start_run(16'd4);
        wait_done("c_done", 12);
`ifdef FIFO_READER_SEQCHECK_EN
        exp_err = 32'd1;
`else
        exp_err = 32'd0;
`endif
        chk("c_ec", 32'(err_count), exp_err);
        chk("c_wc", 32'(word_count), 32'd4);

        // Zero-length run with data waiting upstream.
        load(32'd99, 1);
        start_run(16'd0);
        chk("d_done", {31'd0, done}, 32'd1);
        chk("d_deq", {31'd0, fifo_deq__ENA}, 32'd0);
        chk("d_wc", 32'(word_count), 32'd0);
        tick();
        #1;
        chk("d_deq_cnt", 32'(deq_cnt), 32'd0);
        chk("d_still_done", {31'd0, done}, 32'd1);

        // Start pulse during RUN must not reload the run.
        load(32'd40, 3);
        start_run(16'd3);
        chk("e_start_rdy_run", {31'd0, start__RDY}, 32'd0);
        start_n    = 16'd7;
        start__ENA = 1'b1;
        tick();
        start__ENA = 1'b0;
        wait_done("e_done", 12);
        chk("e_wc", 32'(word_count), 32'd3);
        chk("e_deq_cnt", 32'(deq_cnt), 32'd3);
        chk_rx("e", 32'd40, 3);

        // Reset mid-run after two captures.
        load(32'd50, 6);
        start_run(16'd6);
        chk("f_deq0", {31'd0, fifo_deq__ENA}, 32'd1);
        tick();
        #1;
        chk("f_deq1", {31'd0, fifo_deq__ENA}, 32'd1);
        tick();
        #1;
        chk("f_wc2", 32'(word_count), 32'd2);
        nRST = 1'b0;
        #1;
        chk("f_rst_deq", {31'd0, fifo_deq__ENA}, 32'd0);
        chk("f_rst_enq", {31'd0, sink_enq__ENA}, 32'd0);
        chk("f_rst_rr", {31'd0, rule_ready}, 32'd0);
        tick();
        nRST = 1'b1;
        #1;
        chk("f_start_rdy", {31'd0, start__RDY}, 32'd1);
        chk("f_done", {31'd0, done}, 32'd0);
        chk("f_wc", 32'(word_count), 32'd0);
        chk("f_ec", 32'(err_count), 32'd0);
        chk("f_sink_v", sink_enq_v, 32'd0);
        chk("f_deq_cnt", 32'(deq_cnt), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/l_class_oc_fifo_reader.md
L_CLASS_OC_FIFO_READER -- requirements
Module: l_class_OC_FifoReader

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of start_n, word_count and err_count.
REQ-002 SHALL have CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 SHALL have nRST  input  1  reset, synchronous and active-low.
REQ-004 SHALL have start__ENA  input  1  begin a run; start_n  input  CNT_W  number of words to drain; start__RDY  output  1  start accepted this cycle.
REQ-005 SHALL have fifo_deq__ENA  output  1  and fifo_deq__RDY  input  1  as the initiator of an upstream FIFO deq method.
REQ-006 SHALL have fifo_first  input  32  head data and fifo_first__RDY  input  1  head valid, both from the upstream FIFO.
REQ-007 SHALL have sink_enq__ENA  output  1, sink_enq_v  output  32 and sink_enq__RDY  input  1  as the initiator of a downstream enq method.
REQ-008 SHALL have done  output  1, word_count  output  CNT_W  words captured this run, err_count  output  CNT_W  sequence errors this run.
REQ-009 SHALL have rule_enable  input  1  drain-rule enable and rule_ready  output  1  drain-rule guard.

Function
REQ-010 SHALL implement states IDLE, RUN and DONE; start__RDY = (state==IDLE or DONE).
REQ-011 SHALL, on start__ENA && start__RDY, load remaining=start_n, clear word_count and err_count, clear the hold register, and enter RUN; if start_n==0, enter DONE instead.
REQ-012 SHALL ignore start__ENA while in RUN.
REQ-013 SHALL drive rule_ready = RUN && remaining!=0 && fifo_deq__RDY && fifo_first__RDY && (!hold_valid || sink_enq__RDY).
REQ-014 SHALL fire the drain rule when rule_enable && rule_ready; in the same cycle it asserts fifo_deq__ENA=1, and at the clock edge captures fifo_first into hold_data, sets hold_valid, decrements remaining and increments word_count.
REQ-015 SHALL never assert fifo_deq__ENA unless the drain rule fires.
REQ-016 SHALL drive sink_enq__ENA = hold_valid && sink_enq__RDY and sink_enq_v = hold_data; on sink_enq__ENA without a drain fire, clear hold_valid.
REQ-017 SHALL, on a simultaneous drain fire and sink_enq__ENA, keep hold_valid=1 with the new data, sustaining 1 word/cycle.
REQ-018 SHALL have a fifo_first-to-sink_enq_v latency of exactly 1 cycle when sink_enq__RDY is high.
REQ-019 SHALL transition RUN->DONE at the edge where remaining==0 and hold_valid is clear after that edge.
REQ-020 SHALL assert done=1 only in DONE; it stays 1 until the next accepted start.
REQ-021 SHALL hold word_count at most start_n; it does not wrap.

Reset
REQ-022 SHALL, on nRST low at a clock edge, set state=IDLE, remaining=0, hold_valid=0, hold_data=0, word_count=0, err_count=0 and expected=0.
REQ-023 SHALL force fifo_deq__ENA=0, sink_enq__ENA=0 and rule_ready=0 combinationally while nRST is low, including on a reset asserted mid-RUN.
REQ-024 SHALL drive, after reset, start__RDY=1, done=0, sink_enq_v=0, word_count=0 and err_count=0.

Configuration
REQ-025 SHALL, with FIFO_READER_SEQCHECK_EN defined, keep a 32-bit expected register: the first word captured in a run sets expected=word+1 with no error; each later captured word != expected increments err_count (saturating at all-ones); expected then becomes observed+1.
REQ-026 SHALL, without FIFO_READER_SEQCHECK_EN, have no expected register and tie err_count to 0; all other behaviour is unchanged.

Verification
REQ-027 SHALL pass this test: reset, then start_n=4, upstream holds 10,11,12,13, sink always ready, rule_enable=1 -> 4 consecutive deq cycles, sink_enq_v 10..13 on consecutive cycles, word_count=4, err_count=0, done=1.
REQ-028 SHALL pass this test: start_n=3, sink_enq__RDY low for 5 cycles after the first capture -> exactly one deq, hold keeps the first word, rule_ready=0 while the hold is full, all 3 words delivered in order after release.
REQ-029 SHALL pass this test: SEQCHECK_EN, words 5,6,9,10 -> err_count=1; without the macro -> err_count=0.
REQ-030 SHALL pass this test: start_n=0 -> DONE on the next cycle, no deq, done=1.
REQ-031 SHALL pass this test: nRST low for 1 cycle mid-RUN after 2 of 6 words -> fifo_deq__ENA and sink_enq__ENA are 0 in the reset cycle, state=IDLE, counters=0, start__RDY=1.
REQ-032 SHALL pass this test: start__ENA pulsed during RUN -> ignored; remaining and word_count are unaffected.
